// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, port ids
// and the default burst bound.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin chooser: decides who owns the memory next cycle from the
// live requests, the current owner and whether that owner's burst has run out.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic       busy,
    input  logic       owner,
    input  logic       burst_expired,
    output logic       next_owner,
    output logic       next_en
);

    logic other;

    always_comb begin
        other      = ~owner;
        next_owner = owner;
        next_en    = 1'b0;
        if (!busy) begin
            // Ties from idle go to whoever was not served last.
            if (req == 2'b11) begin
                next_owner = ~last_served;
                next_en    = 1'b1;
            end else if (req[PORT_CPU]) begin
                next_owner = PORT_CPU;
                next_en    = 1'b1;
            end else if (req[PORT_LDR]) begin
                next_owner = PORT_LDR;
                next_en    = 1'b1;
            end
        end else if (req[owner]) begin
            next_en    = 1'b1;
            next_owner = (req[other] && burst_expired) ? other : owner;
        end else if (req[other]) begin
            next_en    = 1'b1;
            next_owner = other;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one unified memory between the core (port 0) and
// the loader/DMA master (port 1), with bounded bursts and registered read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t       state, state_next;
    logic             last_served;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
    logic             busy, owner, burst_expired;
    logic             next_owner, next_en;

    assign busy          = (state != IDLE);
    assign owner         = (state == GNT1);
    assign burst_expired = (burst_cnt == CNT_MAX);

    arb_rr_pick u_pick (
        .req           ({p1_req, p0_req}),
        .last_served   (last_served),
        .busy          (busy),
        .owner         (owner),
        .burst_expired (burst_expired),
        .next_owner    (next_owner),
        .next_en       (next_en)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= PORT_LDR;
            burst_cnt   <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            if (busy) last_served <= owner;
        end
    end

    always_comb begin
        state_next     = IDLE;
        burst_cnt_next = '0;
        p0_gnt         = (state == GNT0) & p0_req;
        p1_gnt         = (state == GNT1) & p1_req;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        if (next_en) state_next = next_owner ? GNT1 : GNT0;
        // Staying with the same owner implies it was granted; any switch or idle clears.
        if (busy && state_next == state)
            burst_cnt_next = burst_expired ? burst_cnt : burst_cnt + 1'b1;

        // Writes are masked by reset so an access aborted by reset never lands.
        case (state)
            GNT0: begin
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
                mem_we    = p0_we & p0_gnt & reset;
            end
            GNT1: begin
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
                mem_we    = p1_we & p1_gnt & reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p0_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rdata  <= '0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt & ~p0_we) p0_rdata <= mem_rdata;
            if (p1_gnt & ~p1_we) p1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a grant-sequence and memory reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we;
    logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          mem_clear = 1'b0;
    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] ref_mem [0:255];
    int            n_checks = 0;
    int            n_fail = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // clock / memory environment
    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else if (mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic apply_reset(input int n);
        reset = 1'b0; mem_clear = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b1; mem_clear = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hA5A5_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
            n_checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b%0b want 00", p1_gnt, p0_gnt); end
            n_checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b%0b want 00", p1_rvalid, p0_rvalid); end
            n_checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %0h/%0h want 0/0", p0_rdata, p1_rdata); end
        end
        @(posedge clk); #1 reset = 1'b1; mem_clear = 1'b0;
        @(negedge clk);
        n_checks++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_arb_latency: got %0b want 0", p0_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_first_gnt0: got %0b want 1", p0_gnt); end
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL reset_first_write: got we=%0b addr=%0h want we=1 addr=10", mem_we, mem_addr); end
        ref_mem[8'h10] = 32'hA5A5_0001;
        @(posedge clk); #1 p0_req = 1'b0;
    endtask

    task automatic test_single_port();
        idle_cycles(2);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL sp_idle_gnt: got %0b want 0", p0_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL sp_write_gnt: got %0b%0b want 01", p1_gnt, p0_gnt); end
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_write_bus: got we=%0b addr=%0h data=%0h want 1/40/deadbeef", mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1 p0_we = 1'b0; p0_wdata = '0;
        @(negedge clk);
        n_checks++; if (p0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL sp_read_gnt: got gnt=%0b we=%0b addr=%0h want 1/0/40", p0_gnt, mem_we, mem_addr); end
        n_checks++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL sp_rvalid_after_write: got %0b want 0", p0_rvalid); end
        @(posedge clk); #1 p0_req = 1'b0;
        @(negedge clk);
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_read_data: got v=%0b d=%0h want 1/deadbeef", p0_rvalid, p0_rdata); end
        n_checks++; if (p1_gnt !== 1'b0) begin n_fail++; $display("FAIL sp_p1_gnt: got %0b want 0", p1_gnt); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sp_rdata_hold: got v=%0b d=%0h want 0/deadbeef", p0_rvalid, p0_rdata); end
        ref_mem[8'h40] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        bit e0, e1, prev0, prev1;
        apply_reset(2);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h8;
        prev0 = 1'b0; prev1 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            e0 = (k >= 1) && (((k - 1) / MB) % 2 == 0);
            e1 = (k >= 1) && !e0;
            @(negedge clk);
            n_checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin
                n_fail++; $display("FAIL rr_seq[%0d]: got %0b%0b want %0b%0b", k, p1_gnt, p0_gnt, e1, e0); end
            n_checks++; if (p0_rvalid !== prev0 || p1_rvalid !== prev1) begin
                n_fail++; $display("FAIL rr_rvalid[%0d]: got %0b%0b want %0b%0b", k, p1_rvalid, p0_rvalid, prev1, prev0); end
            prev0 = e0; prev1 = e1;
            @(posedge clk); #1;
        end
        idle_cycles(3);
    endtask

    task automatic test_late_contender();
        int seq [7] = '{0, 2, 2, 2, 2, 1, 1};
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'hC;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++; if (p0_gnt !== (seq[k] == 1) || p1_gnt !== (seq[k] == 2)) begin
                n_fail++; $display("FAIL late_seq[%0d]: got %0b%0b want owner %0d", k, p1_gnt, p0_gnt, seq[k]); end
            @(posedge clk); #1;
            if (k == 1) begin p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h14; end
        end
        idle_cycles(3);
    endtask

    task automatic test_drop_switch();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h18;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1 || k == 2) begin
                n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_gnt0[%0d]: got %0b want 1", k, p0_gnt); end
            end else if (k == 3) begin
                n_checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_cycle: got %0b%0b want 00", p1_gnt, p0_gnt); end
            end else if (k == 4) begin
                n_checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_no_bubble: got %0b%0b want 10", p1_gnt, p0_gnt); end
            end
            @(posedge clk); #1;
            if (k == 2) begin p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h1C; end
        end
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_burst();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h80; p1_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (p1_gnt !== 1'b0) begin n_fail++; $display("FAIL rmb_idle: got %0b want 0", p1_gnt); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rmb_abort: got gnt=%0b we=%0b want 1/0", p1_gnt, mem_we); end
        @(posedge clk); #1;
        reset = 1'b1; p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h80;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmb_p1_rvalid[%0d]: got %0b want 0", k, p1_rvalid); end
            if (k == 2) begin
                n_checks++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL rmb_restart_idle: got %0b want 0", p0_gnt); end
            end else if (k == 3) begin
                n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL rmb_p0_gnt: got %0b want 1", p0_gnt); end
            end else begin
                n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL rmb_read_back: got v=%0b d=%0h want 1/0", p0_rvalid, p0_rdata); end
            end
            @(posedge clk); #1;
            if (k == 3) p0_req = 1'b0;
        end
        idle_cycles(3);
    endtask

    task automatic test_random();
        int owner, nxt, run, last, rate0, rate1;
        bit r [2];
        bit g0, g1, rv0, rv1;
        logic [DW-1:0] rd0, rd1;
        logic [31:0] tmp;
        apply_reset(2);
        owner = -1; run = 0; last = 1;
        rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
        for (int c = 0; c < 600; c++) begin
            rate0 = (c < 200) ? 30 : (c < 400) ? 80 : 100;
            rate1 = (c < 200) ? 40 : (c < 400) ? 60 : 100;
            @(negedge clk);
            r[0] = p0_req; r[1] = p1_req;
            g0 = (owner == 0) && r[0];
            g1 = (owner == 1) && r[1];
            n_checks++; if (p0_gnt !== g0 || p1_gnt !== g1) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got %0b%0b want %0b%0b", c, p1_gnt, p0_gnt, g1, g0); end
            n_checks++; if (p0_rvalid !== rv0 || p1_rvalid !== rv1) begin
                n_fail++; $display("FAIL rnd_rvalid[%0d]: got %0b%0b want %0b%0b", c, p1_rvalid, p0_rvalid, rv1, rv0); end
            n_checks++; if (p0_rdata !== rd0 || p1_rdata !== rd1) begin
                n_fail++; $display("FAIL rnd_rdata[%0d]: got %0h/%0h want %0h/%0h", c, p0_rdata, p1_rdata, rd0, rd1); end
            n_checks++;
            if (g0 && (mem_addr !== p0_addr || mem_we !== p0_we || (p0_we && mem_wdata !== p0_wdata))) begin
                n_fail++; $display("FAIL rnd_bus0[%0d]: got we=%0b a=%0h d=%0h want we=%0b a=%0h d=%0h", c, mem_we, mem_addr, mem_wdata, p0_we, p0_addr, p0_wdata);
            end else if (g1 && (mem_addr !== p1_addr || mem_we !== p1_we || (p1_we && mem_wdata !== p1_wdata))) begin
                n_fail++; $display("FAIL rnd_bus1[%0d]: got we=%0b a=%0h d=%0h want we=%0b a=%0h d=%0h", c, mem_we, mem_addr, mem_wdata, p1_we, p1_addr, p1_wdata);
            end else if (!g0 && !g1 && mem_we !== 1'b0) begin
                n_fail++; $display("FAIL rnd_idle_we[%0d]: got %0b want 0", c, mem_we);
            end
            // memory effects of this cycle's access
            rv0 = g0 && !p0_we;
            rv1 = g1 && !p1_we;
            if (rv0) rd0 = ref_mem[p0_addr[7:0]];
            if (rv1) rd1 = ref_mem[p1_addr[7:0]];
            if (g0 && p0_we) ref_mem[p0_addr[7:0]] = p0_wdata;
            if (g1 && p1_we) ref_mem[p1_addr[7:0]] = p1_wdata;
            // who owns the memory next cycle; run = grants so far in this tenure
            if (owner < 0) begin
                if (r[0] && r[1]) nxt = 1 - last;
                else if (r[0]) nxt = 0;
                else if (r[1]) nxt = 1;
                else nxt = -1;
            end else begin
                last = owner;
                if (r[owner]) begin
                    run++;
                    nxt = (r[1 - owner] && run >= MB) ? 1 - owner : owner;
                end else begin
                    nxt = r[1 - owner] ? 1 - owner : -1;
                end
            end
            if (nxt != owner) run = 0;
            owner = nxt;
            @(posedge clk); #1;
            if (g0 || !p0_req) begin
                tmp = $urandom;
                p0_req = ($urandom_range(0, 99) < rate0);
                p0_we = 1'($urandom_range(0, 1));
                p0_addr = {tmp[31:8], 8'($urandom_range(0, 15))};
                p0_wdata = $urandom;
            end
            if (g1 || !p1_req) begin
                tmp = $urandom;
                p1_req = ($urandom_range(0, 99) < rate1);
                p1_we = 1'($urandom_range(0, 1));
                p1_addr = {tmp[31:8], 8'($urandom_range(0, 15))};
                p1_wdata = $urandom;
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_late_contender();
        test_drop_switch();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
